// File: rtl/pipe_hold_ctrl_if.sv
// Hazard/wait inputs and encoded hold/redirect outputs shared between the
// pipeline stages and the hold controller.
interface pipe_hold_ctrl_if #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned HoldFlagWidth = 3
);
  logic                     ExIsLoad;
  logic [4:0]               ExRdAddr;
  logic [4:0]               IdRs1Addr;
  logic [4:0]               IdRs2Addr;
  logic                     IdRs1Used;
  logic                     IdRs2Used;
  logic                     ExJumpFlag;
  logic [AddrWidth-1:0]     ExJumpAddr;
  logic                     MulDivStart;
  logic                     MulDivDone;
  logic                     MemReq;
  logic                     MemReady;
  logic [HoldFlagWidth-1:0] HoldFlagToRegs;
  logic                     JumpFlagOut;
  logic [AddrWidth-1:0]     JumpAddrOut;
  logic [31:0]              StallCycles;

  modport master (
    output ExIsLoad, ExRdAddr, IdRs1Addr, IdRs2Addr, IdRs1Used, IdRs2Used,
           ExJumpFlag, ExJumpAddr, MulDivStart, MulDivDone, MemReq, MemReady,
    input  HoldFlagToRegs, JumpFlagOut, JumpAddrOut, StallCycles
  );

  modport slave (
    input  ExIsLoad, ExRdAddr, IdRs1Addr, IdRs2Addr, IdRs1Used, IdRs2Used,
           ExJumpFlag, ExJumpAddr, MulDivStart, MulDivDone, MemReq, MemReady,
    output HoldFlagToRegs, JumpFlagOut, JumpAddrOut, StallCycles
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: prioritises memory, mul/div, jump and
// load-use hazards into one hold code and counts stalled cycles.
module pipe_hold_ctrl #(
  parameter int unsigned FlushCycles   = 1,
  parameter int unsigned HoldFlagWidth = 3,
  parameter int unsigned AddrWidth     = 64
) (
  input logic           Clk,
  input logic           Rst,
  pipe_hold_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_MD_WAIT, S_FLUSH} state_t;

  localparam logic [HoldFlagWidth-1:0] HF_NONE   = HoldFlagWidth'(0);
  localparam logic [HoldFlagWidth-1:0] HF_BUBBLE = HoldFlagWidth'(1);
  localparam logic [HoldFlagWidth-1:0] HF_FLUSH  = HoldFlagWidth'(2);
  localparam logic [HoldFlagWidth-1:0] HF_STALL  = HoldFlagWidth'(3);
  localparam logic [2:0]               FLUSH_LOAD = 3'(FlushCycles - 1);

  state_t                   r_state, w_next;
  logic [2:0]               r_flush_cnt, w_cnt_next;
  logic [31:0]              r_stall_cnt;
  logic [HoldFlagWidth-1:0] w_hold;
  logic                     w_jump;
  logic                     w_rules;
  logic                     w_skip_r2;
  logic                     w_load_use;
  logic                     w_mem_stall;
  logic                     w_md_stall;

  always_comb begin
    w_load_use  = bus.ExIsLoad && (bus.ExRdAddr != '0) &&
                  ((bus.IdRs1Used && (bus.IdRs1Addr == bus.ExRdAddr)) ||
                   (bus.IdRs2Used && (bus.IdRs2Addr == bus.ExRdAddr)));
    w_mem_stall = bus.MemReq && !bus.MemReady;
    w_md_stall  = bus.MulDivStart && !bus.MulDivDone;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_flush_cnt;
    w_hold     = HF_NONE;
    w_jump     = 1'b0;
    w_rules    = 1'b0;
    w_skip_r2  = 1'b0;
    case (r_state)
      S_RUN: w_rules = 1'b1;
      S_MEM_WAIT: begin
        if (!bus.MemReady) w_hold = HF_STALL;
        else               w_rules = 1'b1;
      end
      S_MD_WAIT: begin
        // MulDivStart still reflects the finishing op, so R2 must not re-fire.
        if (!bus.MulDivDone) w_hold = HF_STALL;
        else begin
          w_rules   = 1'b1;
          w_skip_r2 = 1'b1;
        end
      end
      S_FLUSH: begin
        w_hold     = HF_FLUSH;
        w_cnt_next = r_flush_cnt - 3'(r_flush_cnt != '0);
        if (r_flush_cnt <= 3'd1) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase

    if (w_rules) begin
      w_next = S_RUN;
      if (w_mem_stall) begin
        w_hold = HF_STALL;
        w_next = S_MEM_WAIT;
      end else if (w_md_stall && !w_skip_r2) begin
        w_hold = HF_STALL;
        w_next = S_MD_WAIT;
      end else if (bus.ExJumpFlag) begin
        w_hold     = HF_FLUSH;
        w_jump     = 1'b1;
        w_cnt_next = FLUSH_LOAD;
        w_next     = (FLUSH_LOAD != '0) ? S_FLUSH : S_RUN;
      end else if (w_load_use) begin
        w_hold = HF_BUBBLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_cnt_next;
      if ((w_hold != HF_NONE) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Outputs are Mealy, so they must be forced quiet while reset is held.
  assign bus.HoldFlagToRegs = Rst ? w_hold : '0;
  assign bus.JumpFlagOut    = Rst && w_jump;
  assign bus.JumpAddrOut    = (Rst && w_jump) ? bus.ExJumpAddr : '0;
  assign bus.StallCycles    = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed and random stimulus for pipe_hold_ctrl, checked against a
// queue-based reference model of the hold rules.
module tb_pipe_hold_ctrl;
  localparam int unsigned FC = 2;
  localparam int unsigned AW = 64;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  pipe_hold_ctrl_if #(.AddrWidth(AW), .HoldFlagWidth(3)) bus ();

  pipe_hold_ctrl #(.FlushCycles(FC), .HoldFlagWidth(3), .AddrWidth(AW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Model: which wait the block is parked in, and queued extra FLUSH cycles.
  int unsigned waiting = 0;   // 0 none, 1 memory, 2 mul/div
  int          flush_q[$];
  logic [31:0] exp_stall = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ExIsLoad = 0; bus.ExRdAddr = 0; bus.IdRs1Addr = 0; bus.IdRs2Addr = 0;
    bus.IdRs1Used = 0; bus.IdRs2Used = 0; bus.ExJumpFlag = 0; bus.ExJumpAddr = '0;
    bus.MulDivStart = 0; bus.MulDivDone = 0; bus.MemReq = 0; bus.MemReady = 0;
  endtask

  task automatic model_reset();
    waiting = 0;
    flush_q.delete();
    exp_stall = '0;
  endtask

  // Inputs are set by the caller after a posedge; outputs are compared at
  // the following negedge and the model commits across the next posedge.
  task automatic tick(input string tag);
    logic [2:0]  eh;
    logic        ejf;
    logic [63:0] ea;
    int unsigned from;
    logic        lu;
    @(negedge Clk);
    eh = 0; ejf = 0; ea = '0;
    lu = bus.ExIsLoad && bus.ExRdAddr != 0 &&
         ((bus.IdRs1Used && bus.IdRs1Addr == bus.ExRdAddr) ||
          (bus.IdRs2Used && bus.IdRs2Addr == bus.ExRdAddr));
    if (flush_q.size() > 0) begin
      eh = 3'd2;
      void'(flush_q.pop_front());
    end else if (waiting == 1 && !bus.MemReady) eh = 3'd3;
    else if (waiting == 2 && !bus.MulDivDone) eh = 3'd3;
    else begin
      from = waiting;
      waiting = 0;
      if (bus.MemReq && !bus.MemReady) begin
        eh = 3'd3; waiting = 1;
      end else if (from != 2 && bus.MulDivStart && !bus.MulDivDone) begin
        eh = 3'd3; waiting = 2;
      end else if (bus.ExJumpFlag) begin
        eh = 3'd2; ejf = 1; ea = bus.ExJumpAddr;
        for (int i = 1; i < int'(FC); i++) flush_q.push_back(2);
      end else if (lu) eh = 3'd1;
    end
    check($sformatf("%s.hold", tag), 64'(bus.HoldFlagToRegs), 64'(eh));
    check($sformatf("%s.jflag", tag), 64'(bus.JumpFlagOut), 64'(ejf));
    check($sformatf("%s.jaddr", tag), bus.JumpAddrOut, ea);
    check($sformatf("%s.stalls", tag), 64'(bus.StallCycles), 64'(exp_stall));
    @(posedge Clk);
    if (eh != 0 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    #1;
  endtask

  initial begin
    idle();
    bus.ExJumpFlag = 1; bus.ExJumpAddr = 64'hDEAD_BEEF; bus.MemReq = 1;
    bus.ExIsLoad = 1; bus.ExRdAddr = 7; bus.IdRs1Used = 1; bus.IdRs1Addr = 7;
    #3;
    check("rst.hold", 64'(bus.HoldFlagToRegs), 64'd0);
    check("rst.jflag", 64'(bus.JumpFlagOut), 64'd0);
    check("rst.jaddr", bus.JumpAddrOut, 64'd0);
    check("rst.stalls", 64'(bus.StallCycles), 64'd0);
    idle();
    @(posedge Clk); #1;
    Rst = 1;
    model_reset();
    tick("idle0");

    // Load-use on rs2, then the bubble clears it.
    bus.ExIsLoad = 1; bus.ExRdAddr = 5; bus.IdRs2Used = 1; bus.IdRs2Addr = 5;
    tick("lu");
    check("lu.exp_bubble_seen", 64'(exp_stall), 64'd1);
    idle(); tick("lu_after");
    bus.ExIsLoad = 1; bus.ExRdAddr = 0; bus.IdRs2Used = 1; bus.IdRs2Addr = 0;
    tick("lu_x0");
    idle();

    // Jump with two flush cycles.
    bus.ExJumpFlag = 1; bus.ExJumpAddr = 64'h8000_0040;
    tick("jmp");
    idle(); tick("jmp_f2");
    tick("jmp_done");

    // Memory wait for four cycles, released on the fifth.
    bus.MemReq = 1;
    for (int i = 0; i < 4; i++) tick("memw");
    bus.MemReady = 1; tick("mem_rel");
    idle(); tick("mem_after");

    // Mul/div for three cycles, jump arriving with done.
    bus.MulDivStart = 1;
    for (int i = 0; i < 3; i++) tick("mdw");
    bus.MulDivDone = 1; bus.ExJumpFlag = 1; bus.ExJumpAddr = 64'h0000_0000_1234_5678;
    tick("md_rel_jmp");
    idle(); tick("md_f2");
    tick("md_run");

    // All three hazards together: memory wins, then mul/div, then the jump.
    bus.MemReq = 1; bus.MulDivStart = 1; bus.ExJumpFlag = 1; bus.ExJumpAddr = 64'hABCD;
    tick("prio");
    bus.MemReady = 1; tick("prio_memrel");
    bus.MemReq = 0; bus.MemReady = 0; tick("prio_mdw");
    bus.MulDivDone = 1; tick("prio_mdrel");
    idle(); tick("prio_f2"); tick("prio_run");

    // Reset dropped in the middle of a mul/div wait.
    bus.MulDivStart = 1;
    tick("pre_rst0"); tick("pre_rst1");
    Rst = 0;
    #1;
    check("midrst.hold", 64'(bus.HoldFlagToRegs), 64'd0);
    check("midrst.jflag", 64'(bus.JumpFlagOut), 64'd0);
    check("midrst.stalls", 64'(bus.StallCycles), 64'd0);
    @(posedge Clk); #1;
    idle(); Rst = 1;
    model_reset();
    tick("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.MemReq      = ($urandom_range(0, 3) == 0);
      bus.MemReady    = ($urandom_range(0, 1) == 0);
      bus.MulDivStart = ($urandom_range(0, 3) == 0);
      bus.MulDivDone  = ($urandom_range(0, 2) == 0);
      bus.ExJumpFlag  = ($urandom_range(0, 5) == 0);
      bus.ExJumpAddr  = {$urandom, $urandom};
      bus.ExIsLoad    = ($urandom_range(0, 1) == 0);
      bus.ExRdAddr    = 5'($urandom_range(0, 3));
      bus.IdRs1Addr   = 5'($urandom_range(0, 3));
      bus.IdRs2Addr   = 5'($urandom_range(0, 3));
      bus.IdRs1Used   = ($urandom_range(0, 1) == 0);
      bus.IdRs2Used   = ($urandom_range(0, 1) == 0);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Pipeline hold/flush controller for the five-stage RV64 core. It gathers hazard and wait conditions from ID, EX and MEM, and drives the single encoded HoldFlag bus consumed by the PC register and the IF/ID, ID/EX and EX/MEM stage registers. The stage registers only act on that code; every decision about when to stall, bubble or flush is made here. It also redirects fetch on a taken jump/branch and keeps a stall-cycle performance counter.

## Interface
- FlushCycles, default 1: number of consecutive FLUSH cycles issued per taken jump; legal range 1..7.
- HoldFlagWidth, default 3: width of `HoldFlagBus`.

Ports (name, direction, width, meaning):
- Clk  in  1  core clock; all state is updated on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ExIsLoad  in  1  the instruction in ID/EX is a load.
- ExRdAddr  in  5  destination register of the ID/EX instruction.
- IdRs1Addr, IdRs2Addr  in  5 each  source registers of the instruction in decode.
- IdRs1Used, IdRs2Used  in  1 each  the decode instruction actually reads rs1 / rs2.
- ExJumpFlag  in  1  EX resolved a taken jump or branch.
- ExJumpAddr  in  `AddrBus`  target of that jump.
- MulDivStart  in  1  EX holds a multi-cycle mul/div operation.
- MulDivDone  in  1  mul/div result is valid this cycle.
- MemReq  in  1  MEM stage has an outstanding data access.
- MemReady  in  1  data bus completes the access this cycle.
- HoldFlagToRegs  out  `HoldFlagBus`  encoded hold code to the PC and stage registers.
- JumpFlagOut  out  1  redirect PC this cycle.
- JumpAddrOut  out  `AddrBus`  redirect target.
- StallCycles  out  32  number of cycles in which HoldFlagToRegs was not NONE.

## Operation
HoldFlag codes:
- 0 NONE: all registers load.
- 1 BUBBLE: PC and IF/ID hold; ID/EX loads zeros.
- 2 FLUSH: IF/ID and ID/EX load zeros; PC loads the redirect target.
- 3 STALL_ALL: PC, IF/ID, ID/EX and EX/MEM hold.
- 4..7: reserved, never driven.

States are RUN, MEM_WAIT, MD_WAIT and FLUSH. All outputs are Mealy-combinational from the current state and inputs.

RUN uses these rules, in priority order:
- R1: MemReq && !MemReady → STALL_ALL; next state MEM_WAIT.
- R2: MulDivStart && !MulDivDone → STALL_ALL; next state MD_WAIT.
- R3: ExJumpFlag → FLUSH, JumpFlagOut=1, JumpAddrOut=ExJumpAddr. Load flush counter with FlushCycles-1. Next state is FLUSH if the loaded value is nonzero, else RUN.
- R4: load-use → BUBBLE; stay in RUN. Load-use means ExIsLoad && ExRdAddr!=0 && ((IdRs1Used && IdRs1Addr==ExRdAddr) || (IdRs2Used && IdRs2Addr==ExRdAddr)).
- R5: otherwise NONE.

MEM_WAIT:
- While !MemReady: STALL_ALL, stay in MEM_WAIT.
- Release cycle (MemReady=1): evaluate R2–R5 as in RUN, including their next-state effects.

MD_WAIT:
- While !MulDivDone: STALL_ALL, stay in MD_WAIT.
- Release cycle (MulDivDone=1): evaluate R1, R3, R4, R5 in that order.
- R2 is skipped in this cycle because MulDivStart is still high for the same operation.

FLUSH:
- Drive FLUSH with JumpFlagOut=0.
- ExJumpFlag is ignored; EX holds a bubble.
- Decrement the counter each cycle; go to RUN in the cycle it reads 0.

General rules:
- JumpFlagOut is asserted only in the R3 cycle. JumpAddrOut is 0 whenever JumpFlagOut=0.
- Simultaneous conditions resolve strictly by priority. A jump coincident with a stall is not lost: EX is held, so ExJumpFlag re-presents after release.
- StallCycles increments by 1 on each edge where HoldFlagToRegs != 0 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - state RUN, flush counter 0, StallCycles 0.
  - While Rst=0, HoldFlagToRegs=0, JumpFlagOut=0, JumpAddrOut=0, regardless of inputs.
- Reset asserted mid-wait or mid-flush returns the block to RUN immediately; nothing pending is retained.
- Zero-latency decisions: the hold code in cycle N reflects the inputs in cycle N and takes effect at the edge ending cycle N.
- A load-use hazard yields exactly one BUBBLE cycle; the next cycle the hazard is gone because ID/EX holds the bubble.
- A jump yields exactly FlushCycles FLUSH cycles, the first of which carries the redirect.
- A wait state lasts until the ready/done cycle inclusive of release. A release whose ready/done coincides with the entry condition costs 0 stall cycles.

## Test plan
- Load-use: ExIsLoad=1, ExRdAddr=5, IdRs2Used=1, IdRs2Addr=5 → exactly one cycle of HoldFlag=1, then 0. Repeat with ExRdAddr=0 → HoldFlag stays 0.
- Jump with FlushCycles=2: ExJumpFlag=1, ExJumpAddr=0x8000_0040 for one cycle → JumpFlagOut=1 with that address, then HoldFlag=2 for 2 cycles, then 0. StallCycles=2.
- Memory wait: MemReq=1, MemReady=0 for 4 cycles, then 1 → HoldFlag=3 for 4 cycles, then 0 in the release cycle. StallCycles=4.
- Mul/div stall then jump: MulDivStart=1 with Done after 3 cycles, and ExJumpFlag=1 in the Done cycle → 3 cycles of HoldFlag=3, then FLUSH with redirect in the release cycle, then back to RUN.
- Priority: MemReq&&!MemReady, MulDivStart and ExJumpFlag all asserted together → HoldFlag=3, state MEM_WAIT, JumpFlagOut=0.
- Reset mid-operation: drop Rst in MD_WAIT while MulDivDone=0 → outputs read 0 immediately and StallCycles reads 0. After release with idle inputs, HoldFlag=0 in the first cycle.
